// File: rtl/ex_mem_result_buf.sv
// ---------------------------------------------------------------------------
// ex_mem_result_buf
//   EX->MEM pipeline result buffer. Each retired EX op (ALU result plus
//   control) is captured into a two-entry skid buffer made of a head entry
//   ("main", drives out_*) and an overflow entry ("skid"). Both sides use
//   valid/ready handshakes. The buffer also performs an operand-forwarding
//   lookup for the op currently in EX and raises a load-use stall.
//
// Handshake rule: a beat transfers on a rising edge where valid and ready
// are both high. The producer holds valid and payload stable until that
// edge. Ready may depend on nothing but registered state.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous kill of both entries
//   in_valid/in_ready   EX-side handshake (in_ready = !skid_valid)
//   in_*                EX result fields
//   out_valid/out_ready MEM-side handshake on the head entry
//   out_*               head entry fields (registered)
//   ex_rs1, ex_rs2      source register indices of the op in EX
//   fwd_rsN_hit/data    forwarding select and data for each operand
//   fwd_stall           a matching producer is a load
// ---------------------------------------------------------------------------
module ex_mem_result_buf #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  output logic              fwd_rs1_hit,
  output logic [XLEN-1:0]   fwd_rs1_data,
  output logic              fwd_rs2_hit,
  output logic [XLEN-1:0]   fwd_rs2_data,
  output logic              fwd_stall
);

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  assign in_entry = '{alu_result: in_alu_result, store_data: in_store_data,
                      rd: in_rd, reg_write: in_reg_write,
                      mem_read: in_mem_read, mem_write: in_mem_write};

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid_q & out_ready;

  // Buffer next-state. The skid entry is always the younger one, so when the
  // head frees up it is refilled from skid before any new input.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = in_entry;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_alu_result = main_q.alu_result;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;

  function automatic logic produces(input logic v, input entry_t e,
                                    input logic [REG_AW-1:0] x);
    return v & e.reg_write & (e.rd == x) & (x != '0);
  endfunction

  // Forwarding lookup: skid holds the younger producer, so it wins. A load
  // cannot forward yet; it stalls EX instead.
  logic skid_p1, main_p1, skid_p2, main_p2;
  logic load1, load2, any1, any2;

  always_comb begin
    skid_p1      = produces(skid_valid_q, skid_q, ex_rs1);
    main_p1      = produces(main_valid_q, main_q, ex_rs1);
    skid_p2      = produces(skid_valid_q, skid_q, ex_rs2);
    main_p2      = produces(main_valid_q, main_q, ex_rs2);
    any1         = skid_p1 | main_p1;
    any2         = skid_p2 | main_p2;
    load1        = skid_p1 ? skid_q.mem_read : main_q.mem_read;
    load2        = skid_p2 ? skid_q.mem_read : main_q.mem_read;
    fwd_rs1_data = skid_p1 ? skid_q.alu_result : main_q.alu_result;
    fwd_rs2_data = skid_p2 ? skid_q.alu_result : main_q.alu_result;
    fwd_rs1_hit  = any1 & ~load1;
    fwd_rs2_hit  = any2 & ~load2;
    fwd_stall    = (any1 & load1) | (any2 & load2);
  end

endmodule
